fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised, pipelined minifloat multiplier; successor to the fixed FP8 demo datapath.
//  Format: sign | EXP_W exponent | MAN_W mantissa, bias 2^(EXP_W-1)-1, IEEE-like specials
//  (exp all-ones: inf if mantissa==0, else NaN). Adds valid/ready flow control, selectable
//  rounding, overflow policy and exception flags. Sits between operand pins and result pins.
// PARAMETERS
//  EXP_W  4  exponent width (3..6)
//  MAN_W  3  stored mantissa width (2..6); W = 1+EXP_W+MAN_W
//  SAT    1  1: overflow saturates to max finite; 0: overflow produces inf
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  operand pair valid
//  in_ready   out  1  block accepts operands this cycle
//  a          in   W  operand A
//  b          in   W  operand B
//  rnd_mode   in   1  0: round-to-nearest-even, 1: truncate; sampled with operands
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  result     out  W  product
//  flags      out  4  {nv, of, uf, nx}, aligned with result
// BEHAVIOUR
//  - Reset: out_valid=0, result=0, flags=0, both stage valids=0. Reset mid-operation
//    drops all in-flight products; no output is emitted for them.
//  - Two register stages: S1 = unpack, sign xor, exponent sum, (MAN_W+1)^2 product;
//    S2 = normalise, round, pack, flags -> output regs. Latency 2 cycles when not stalled.
//  - advance = !out_valid | out_ready; in_ready = advance (combinational). Both stages
//    shift only on advance; transfer when in_valid & in_ready. Full throughput 1/cycle.
//  - Stall (out_valid & !out_ready): result/flags/out_valid held stable; S1 holds.
//  - Bubbles propagate as valid=0; out_valid deasserts after the last result is taken.
//  - Subnormal inputs (exp==0) treated as zero (FTZ). Zero result sign = sign xor.
//  - Product normalisation: if product >= 2.0, shift right 1, exponent +1.
//  - RNE: guard + sticky from dropped bits; tie rounds to even; carry out of mantissa
//    increments exponent. Truncate: drop bits. nx=1 if any dropped bit nonzero.
//  - Overflow (biased exp >= 2^EXP_W-1 after rounding): of=1, nx=1; SAT=1 gives
//    max finite with sign, SAT=0 gives signed inf.
//  - Underflow (biased exp <= 0 before rounding): signed zero, uf=1, nx=1.
//  - Specials: any NaN -> canonical NaN (exp all-ones, mantissa MSB=1, sign 0), nv=0;
//    inf*0 -> canonical NaN, nv=1; inf*finite nonzero -> signed inf, flags 0.
//  - Exact results: flags all 0.
// TESTING (EXP_W=4, MAN_W=3, bias 7, SAT=1 unless stated)
//  1 Exact: 0x3C*0x3C (1.5*1.5) -> 0x41, flags 0; 0xB8*0x40 -> 0xC0; 0x38*0x00 -> 0x00.
//  2 Rounding: 0x39*0x3C (1.6875 tie), rnd_mode=0 -> 0x3E nx; rnd_mode=1 -> 0x3D nx.
//  3 Overflow: 0x77*0x77 -> SAT=1: 0x77 {of,nx}; SAT=0 build: 0x78 {of,nx};
//    underflow 0x08*0x08 -> 0x00 {uf,nx}.
//  4 Specials: 0x78*0x00 -> 0x7C nv; 0x7C*0x38 -> 0x7C no nv; 0xF8*0x40 -> 0xF8.
//  5 Flow: stream 8 back-to-back pairs, out_ready low 3 cycles mid-stream -> in_ready
//    low while stalled, outputs held, all 8 results in order, none lost or duplicated.
//  6 Reset: assert rst_n=0 with 2 products in flight -> out_valid=0 immediately, no
//    stale result after release; random compare vs reference model, all formats.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// Two-stage pipelined minifloat multiplier with valid/ready flow control.
// Stage 1 unpacks and multiplies; stage 2 normalises, rounds, packs and raises flags.
module fp_mul_pipe #(
    parameter int unsigned EXP_W = 4,
    parameter int unsigned MAN_W = 3,
    parameter bit          SAT   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned PW = 2 * (MAN_W + 1);
    localparam int unsigned XW = EXP_W + 2;
    localparam int          BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic [EXP_W-1:0]    EMAX    = '1;
    localparam logic [EXP_W-1:0]    EMAX_M1 = EMAX - 1'b1;
    localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
    localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} cls_e;

    logic                    w_advance;
    logic [EXP_W-1:0]        w_ea, w_eb;
    logic [MAN_W-1:0]        w_fa, w_fb;
    logic                    w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    cls_e                    w_cls;
    logic                    w_nv;
    logic signed [XW-1:0]    w_exp_sum;
    logic [PW-1:0]           w_prod;

    logic                    r_s1_valid, r_s1_sign, r_s1_rnd, r_s1_nv;
    cls_e                    r_s1_cls;
    logic signed [XW-1:0]    r_s1_exp;
    logic [PW-1:0]           r_s1_prod;

    logic                    r_out_valid;
    logic [W-1:0]            r_result;
    logic [3:0]              r_flags;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

    // Stage 1: unpack, classify, exponent sum and significand product
    assign w_ea      = a[W-2:MAN_W];
    assign w_eb      = b[W-2:MAN_W];
    assign w_fa      = a[MAN_W-1:0];
    assign w_fb      = b[MAN_W-1:0];
    assign w_a_zero  = (w_ea == '0);
    assign w_b_zero  = (w_eb == '0);
    assign w_a_inf   = (w_ea == EMAX) && (w_fa == '0);
    assign w_b_inf   = (w_eb == EMAX) && (w_fb == '0);
    assign w_a_nan   = (w_ea == EMAX) && (w_fa != '0);
    assign w_b_nan   = (w_eb == EMAX) && (w_fb != '0);
    assign w_exp_sum = signed'({2'b00, w_ea}) + signed'({2'b00, w_eb}) - BIAS_X;
    assign w_prod    = PW'({1'b1, w_fa}) * PW'({1'b1, w_fb});

    always_comb begin
        w_cls = ClsNorm;
        w_nv  = 1'b0;
        if (w_a_nan || w_b_nan) begin
            w_cls = ClsNan;
        end else if ((w_a_inf || w_b_inf) && (w_a_zero || w_b_zero)) begin
            w_cls = ClsNan;
            w_nv  = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            w_cls = ClsInf;
        end else if (w_a_zero || w_b_zero) begin
            w_cls = ClsZero;
        end
    end

    // Stage 2: normalise so the leading one is implicit, then round
    logic                 w_top, w_guard, w_sticky, w_inc, w_inexact, w_uf, w_of;
    logic [PW-2:0]        w_norm;
    logic [MAN_W-1:0]     w_mant;
    logic [MAN_W:0]       w_mant_r;
    logic signed [XW-1:0] w_exp_n, w_exp_r;
    logic [W-1:0]         w_res;
    logic [3:0]           w_flg;

    assign w_top     = r_s1_prod[PW-1];
    assign w_norm    = w_top ? r_s1_prod[PW-2:0] : {r_s1_prod[PW-3:0], 1'b0};
    assign w_mant    = w_norm[PW-2 -: MAN_W];
    assign w_guard   = w_norm[PW-2-MAN_W];
    assign w_sticky  = |w_norm[PW-3-MAN_W:0];
    assign w_inexact = w_guard || w_sticky;
    assign w_inc     = !r_s1_rnd && w_guard && (w_sticky || w_mant[0]);
    assign w_mant_r  = {1'b0, w_mant} + {{MAN_W{1'b0}}, w_inc};
    assign w_exp_n   = r_s1_exp + signed'({{(XW-1){1'b0}}, w_top});
    assign w_exp_r   = w_exp_n + signed'({{(XW-1){1'b0}}, w_mant_r[MAN_W]});
    assign w_uf      = w_exp_n[XW-1] || (w_exp_n == '0);
    assign w_of      = !w_exp_r[XW-1] && (w_exp_r >= EMAX_X);

    always_comb begin
        w_res = '0;
        w_flg = 4'b0000;
        case (r_s1_cls)
            ClsNan: begin
                w_res = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
                w_flg = {r_s1_nv, 3'b000};
            end
            ClsInf:  w_res = {r_s1_sign, EMAX, {MAN_W{1'b0}}};
            ClsZero: w_res = {r_s1_sign, {(W-1){1'b0}}};
            default: begin
                if (w_uf) begin
                    w_res = {r_s1_sign, {(W-1){1'b0}}};
                    w_flg = 4'b0011;
                end else if (w_of) begin
                    w_flg = 4'b0101;
                    if (SAT) w_res = {r_s1_sign, EMAX_M1, {MAN_W{1'b1}}};
                    else     w_res = {r_s1_sign, EMAX, {MAN_W{1'b0}}};
                end else begin
                    w_res = {r_s1_sign, w_exp_r[EXP_W-1:0], w_mant_r[MAN_W-1:0]};
                    w_flg = {3'b000, w_inexact};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_rnd    <= 1'b0;
            r_s1_nv     <= 1'b0;
            r_s1_cls    <= ClsNorm;
            r_s1_exp    <= '0;
            r_s1_prod   <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (w_advance) begin
            r_s1_valid  <= in_valid;
            r_out_valid <= r_s1_valid;
            if (in_valid) begin
                r_s1_sign <= a[W-1] ^ b[W-1];
                r_s1_rnd  <= rnd_mode;
                r_s1_nv   <= w_nv;
                r_s1_cls  <= w_cls;
                r_s1_exp  <= w_exp_sum;
                r_s1_prod <= w_prod;
            end
            if (r_s1_valid) begin
                r_result <= w_res;
                r_flags  <= w_flg;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: FP8 (4,3) with SAT=1 and SAT=0, plus a (5,2) format instance,
// all driven in lockstep and scored against a real-arithmetic reference model.
module tb_fp_mul_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       rnd = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic       ir0, ir1, ir2, ov0, ov1, ov2;
    logic [7:0] res0, res1, res2;
    logic [3:0] flg0, flg1, flg2;

    int checks = 0;
    int errors = 0;
    int popped = 0;
    logic [11:0] q0[$], q1[$], q2[$];
    logic [11:0] held0;
    bit          held_ok = 1'b0;

    fp_mul_pipe #(.EXP_W(4), .MAN_W(3), .SAT(1'b1)) u_sat1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
        .rnd_mode(rnd), .out_valid(ov0), .out_ready(out_ready), .result(res0), .flags(flg0));
    fp_mul_pipe #(.EXP_W(4), .MAN_W(3), .SAT(1'b0)) u_sat0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
        .rnd_mode(rnd), .out_valid(ov1), .out_ready(out_ready), .result(res1), .flags(flg1));
    fp_mul_pipe #(.EXP_W(5), .MAN_W(2), .SAT(1'b1)) u_e5m2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b),
        .rnd_mode(rnd), .out_valid(ov2), .out_ready(out_ready), .result(res2), .flags(flg2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    // Reference: exact real product, then rounded to the target format. Returns {flags, result}.
    function automatic logic [11:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                            input bit trunc, input int ew, input int mw,
                                            input bit sat);
        int  xi = int'(x);
        int  yi = int'(y);
        int  bias = (1 << (ew - 1)) - 1;
        int  emax = (1 << ew) - 1;
        int  ex = (xi >> mw) & emax;
        int  ey = (yi >> mw) & emax;
        int  fx = xi & ((1 << mw) - 1);
        int  fy = yi & ((1 << mw) - 1);
        int  sgn = ((xi ^ yi) >> 7) & 1;
        int  canon = (emax << mw) | (1 << (mw - 1));
        int  inf = (sgn << 7) | (emax << mw);
        int  e, be, m;
        real v, frac;
        bit  nx;
        if ((ex == emax && fx != 0) || (ey == emax && fy != 0)) return {4'h0, 8'(canon)};
        if (ex == emax || ey == emax) begin
            if (ex == 0 || ey == 0) return {4'h8, 8'(canon)};
            return {4'h0, 8'(inf)};
        end
        if (ex == 0 || ey == 0) return {4'h0, 8'(sgn << 7)};
        v = (1.0 + real'(fx) / pow2(mw)) * pow2(ex - bias) *
            (1.0 + real'(fy) / pow2(mw)) * pow2(ey - bias);
        e = 0;
        while (v >= pow2(e + 1)) e++;
        while (v < pow2(e)) e--;
        be = e + bias;
        if (be <= 0) return {4'h3, 8'(sgn << 7)};
        v = v / pow2(e) * pow2(mw);
        m = $rtoi(v);
        frac = v - real'(m);
        nx = (frac != 0.0);
        if (!trunc && (frac > 0.5 || (frac == 0.5 && (m % 2) == 1))) m++;
        if (m == (2 << mw)) begin
            m = 1 << mw;
            be++;
        end
        if (be >= emax) begin
            if (sat) return {4'h5, 8'((sgn << 7) | ((emax - 1) << mw) | ((1 << mw) - 1))};
            return {4'h5, 8'(inf)};
        end
        return {3'b000, nx, 8'((sgn << 7) | (be << mw) | (m - (1 << mw)))};
    endfunction

    // One cycle: drive at negedge, check outputs/handshake, record accepted operands.
    task automatic tick(input bit v, input bit ordy, input logic [7:0] ta, input logic [7:0] tb,
                        input bit tr, input bit use_k, input logic [11:0] k0,
                        input logic [11:0] k1, output bit acc);
        @(negedge clk);
        in_valid = v; out_ready = ordy; a = ta; b = tb; rnd = tr;
        #1;
        chk("in_ready", {10'b0, ir0, ir2}, {10'b0, !(ov0 && !ordy), !(ov0 && !ordy)});
        chk("valid_align", {10'b0, ov1, ov2}, {10'b0, ov0, ov0});
        if (ov0 && !ordy) begin
            if (held_ok) chk("stall_hold", {flg0, res0}, held0);
            held0   = {flg0, res0};
            held_ok = 1'b1;
        end else begin
            held_ok = 1'b0;
        end
        if (ov0 && ordy) begin
            if (q0.size() == 0) chk("spurious_out", {flg0, res0}, 12'hxxx);
            else chk("res_sat1", {flg0, res0}, q0.pop_front());
            if (q1.size() != 0) chk("res_sat0", {flg1, res1}, q1.pop_front());
            if (q2.size() != 0) chk("res_e5m2", {flg2, res2}, q2.pop_front());
            popped++;
        end
        acc = v && ir0;
        @(posedge clk);
        if (acc) begin
            q0.push_back(use_k ? k0 : ref_mul(ta, tb, tr, 4, 3, 1'b1));
            q1.push_back(use_k ? k1 : ref_mul(ta, tb, tr, 4, 3, 1'b0));
            q2.push_back(ref_mul(ta, tb, tr, 5, 2, 1'b1));
        end
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && (q0.size() + q1.size() + q2.size()) != 0; i++)
            tick(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 12'h0, 12'h0, acc);
        chk("drain_empty", 12'(q0.size() + q1.size() + q2.size()), 12'd0);
    endtask

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        r;
        logic [11:0] k1;
        logic [11:0] k0;
    } dir_t;

    dir_t dirs[10] = '{
        '{8'h3C, 8'h3C, 1'b0, 12'h041, 12'h041},
        '{8'hB8, 8'h40, 1'b0, 12'h0C0, 12'h0C0},
        '{8'h38, 8'h00, 1'b0, 12'h000, 12'h000},
        '{8'h39, 8'h3C, 1'b0, 12'h13E, 12'h13E},
        '{8'h39, 8'h3C, 1'b1, 12'h13D, 12'h13D},
        '{8'h77, 8'h77, 1'b0, 12'h578, 12'h577},
        '{8'h08, 8'h08, 1'b0, 12'h300, 12'h300},
        '{8'h78, 8'h00, 1'b0, 12'h87C, 12'h87C},
        '{8'h7C, 8'h38, 1'b0, 12'h07C, 12'h07C},
        '{8'hF8, 8'h40, 1'b0, 12'h0F8, 12'h0F8}
    };

    initial begin
        bit         acc;
        int         sent;
        logic [7:0] ra, rb;
        bit         rr;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out", {3'b000, ov0, flg0, res0}, 12'h000);
        chk("reset_ready", {11'b0, ir0}, 12'h001);
        rst_n = 1'b1;

        foreach (dirs[i])
            tick(1'b1, 1'b1, dirs[i].a, dirs[i].b, dirs[i].r, 1'b1, dirs[i].k0, dirs[i].k1, acc);
        drain();

        // 8 back-to-back pairs with a 3-cycle consumer stall in the middle
        popped = 0;
        sent   = 0;
        ra = 8'($urandom); rb = 8'($urandom); rr = 1'($urandom);
        for (int c = 0; c < 40 && sent < 8; c++) begin
            tick(1'b1, !(c >= 3 && c <= 5), ra, rb, rr, 1'b0, 12'h0, 12'h0, acc);
            if (c >= 3 && c <= 5) chk("stall_ready_low", {11'b0, acc}, 12'h000);
            if (acc) begin
                sent++;
                ra = 8'($urandom); rb = 8'($urandom); rr = 1'($urandom);
            end
        end
        drain();
        chk("flow_count", 12'(popped), 12'd8);

        // Reset with two products in flight
        tick(1'b1, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0, 12'h0, 12'h0, acc);
        tick(1'b1, 1'b0, 8'h40, 8'h40, 1'b0, 1'b0, 12'h0, 12'h0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        chk("inflight_valid", {9'b0, ov0, ov1, ov2}, 12'h007);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", {9'b0, ov0, ov1, ov2}, 12'h000);
        chk("midreset_out", {flg0, res0}, 12'h000);
        q0.delete(); q1.delete(); q2.delete();
        held_ok = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 12'h0, 12'h0, acc);
            chk("no_stale", {11'b0, ov0}, 12'h000);
        end

        // Random operands, random valid and back-pressure
        for (int i = 0; i < 500; i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 8'($urandom),
                 8'($urandom), 1'($urandom), 1'b0, 12'h0, 12'h0, acc);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
